// File: rtl/avalon_cipher_master_if.sv
// Handshake and Avalon-MM bus bundle for the cipher initiator.
// The master modport is the initiator's view; the slave modport is the opposite side.
interface avalon_cipher_master_if #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned BLK_WORDS = 4,
    parameter int unsigned KEY_WORDS = 4,
    parameter int unsigned RD_WORDS  = 4
);
    logic                            start_valid;
    logic                            start_ready;
    logic [BLK_WORDS*DATA_W-1:0]     blk_in;
    logic [KEY_WORDS*DATA_W-1:0]     key_in;
    logic                            res_valid;
    logic                            res_ready;
    logic [RD_WORDS*DATA_W-1:0]      res_data;
    logic                            err;
    logic                            busy;
    logic                            avm_address;
    logic                            avm_write;
    logic [DATA_W-1:0]               avm_writedata;
    logic                            avm_read;
    logic [DATA_W-1:0]               avm_readdata;
    logic                            avm_waitrequest;

    modport master (
        input  start_valid, blk_in, key_in, res_ready, avm_readdata, avm_waitrequest,
        output start_ready, res_valid, res_data, err, busy,
               avm_address, avm_write, avm_writedata, avm_read
    );

    modport slave (
        output start_valid, blk_in, key_in, res_ready, avm_readdata, avm_waitrequest,
        input  start_ready, res_valid, res_data, err, busy,
               avm_address, avm_write, avm_writedata, avm_read
    );
endinterface

// File: rtl/avalon_cipher_master.sv
// Avalon-MM initiator for the cipher slave: writes block then key words,
// reads the result words back, and presents them on a valid/ready output.
module avalon_cipher_master #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned BLK_WORDS   = 4,
    parameter int unsigned KEY_WORDS   = 4,
    parameter int unsigned RD_WORDS    = 4,
    parameter logic        WR_ADDR     = 1'b1,
    parameter logic        RD_ADDR     = 1'b1,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic                         clk,
    input  logic                         reset,
    avalon_cipher_master_if.master       bus
);
    localparam int unsigned WR_WORDS  = BLK_WORDS + KEY_WORDS;
    localparam int unsigned MAX_WORDS = (WR_WORDS > RD_WORDS) ? WR_WORDS : RD_WORDS;
    localparam int unsigned IDX_W     = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam int unsigned TO_W      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [IDX_W-1:0] LAST_WR = IDX_W'(WR_WORDS - 1);
    localparam logic [IDX_W-1:0] LAST_RD = IDX_W'(RD_WORDS - 1);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t                        state, state_d;
    logic [WR_WORDS*DATA_W-1:0]    shreg;
    logic [RD_WORDS*DATA_W-1:0]    res_q;
    logic [IDX_W-1:0]              idx;
    logic [TO_W-1:0]               wait_cnt;
    logic                          err_q;
    logic                          accept, xfer, stall, timeout;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        accept  = 1'b0;
        xfer    = 1'b0;
        stall   = 1'b0;
        timeout = 1'b0;
        case (state)
            IDLE: if (bus.start_valid) begin
                accept  = 1'b1;
                state_d = WRITE;
            end
            WRITE: if (!bus.avm_waitrequest) begin
                xfer = 1'b1;
                if (idx == LAST_WR) state_d = READ;
            end else begin
                stall = 1'b1;
            end
            READ: if (!bus.avm_waitrequest) begin
                xfer = 1'b1;
                if (idx == LAST_RD) state_d = DONE;
            end else begin
                stall = 1'b1;
            end
            DONE: if (bus.res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // The stall that brings the count to TIMEOUT_CYC aborts on the following edge.
        if (stall && (TIMEOUT_CYC != 0) && (wait_cnt == TO_LAST)) begin
            timeout = 1'b1;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg    <= '0;
            res_q    <= '0;
            idx      <= '0;
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= timeout;
            if (accept) begin
                shreg    <= {bus.key_in, bus.blk_in};
                idx      <= '0;
                wait_cnt <= '0;
            end else if (xfer) begin
                wait_cnt <= '0;
                idx      <= (state_d == state) ? idx + 1'b1 : '0;
                if (state == WRITE) shreg <= shreg >> DATA_W;
                else                res_q <= {bus.avm_readdata, res_q[RD_WORDS*DATA_W-1:DATA_W]};
            end else if (stall) begin
                wait_cnt <= timeout ? '0 : wait_cnt + 1'b1;
            end
        end
    end

    // Bus strobes decode the state register, so reset drops them without a clock.
    assign bus.start_ready   = (state == IDLE);
    assign bus.busy          = (state != IDLE);
    assign bus.res_valid     = (state == DONE);
    assign bus.res_data      = res_q;
    assign bus.err           = err_q;
    assign bus.avm_write     = (state == WRITE);
    assign bus.avm_read      = (state == READ);
    assign bus.avm_writedata = (state == WRITE) ? shreg[DATA_W-1:0] : '0;
    assign bus.avm_address   = (state == WRITE) ? WR_ADDR :
                               (state == READ)  ? RD_ADDR : 1'b0;
endmodule

// File: tb/tb_avalon_cipher_master.sv
// Bench for avalon_cipher_master: a slave model drives waitrequest/readdata and
// compares write order, latency, result assembly, timeout and reset behaviour.
`timescale 1ns/1ps
module tb_avalon_cipher_master;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NBLK   = 4;
    localparam int unsigned NKEY   = 4;
    localparam int unsigned NRD    = 4;
    localparam int unsigned NWR    = NBLK + NKEY;
    localparam int unsigned TO     = 16;

    localparam logic [127:0] B1 = 128'hdeadbeef_fefebabe_12345678_9abcdef0;
    localparam logic [127:0] K1 = 128'h01234567_89abcdef_ffeeddcc_aa998877;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    avalon_cipher_master_if #(.DATA_W(DATA_W), .BLK_WORDS(NBLK), .KEY_WORDS(NKEY), .RD_WORDS(NRD)) bus ();

    avalon_cipher_master #(
        .DATA_W(DATA_W), .BLK_WORDS(NBLK), .KEY_WORDS(NKEY), .RD_WORDS(NRD),
        .WR_ADDR(1'b1), .RD_ADDR(1'b1), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int unsigned n_vec = 0;
    int unsigned n_miss = 0;

`define CHK(TAG, OBS, EXP) begin n_vec++; assert ((OBS) === (EXP)) else begin n_miss++; $error("FAIL %s: observed %0h, expected %0h", TAG, (OBS), (EXP)); end end

    logic [31:0]  exp_wr[$];
    logic [31:0]  got_wr[$];
    logic [31:0]  rd_q[$];
    int           wr_cyc[$];
    int           rd_cyc[$];
    int           res_cyc, err_cnt, err_cyc, held, bad_hold, unstable, sr_bad, proto_bad, rd_stalls, rv_count;
    logic [127:0] res_first;
    logic         idle_after, err_idle;
    bit           timed_out;

    function automatic void build_exp(input logic [127:0] blk, input logic [127:0] key);
        exp_wr.delete();
        for (int i = 0; i < NBLK; i++) exp_wr.push_back(blk[i*32 +: 32]);
        for (int i = 0; i < NKEY; i++) exp_wr.push_back(key[i*32 +: 32]);
    endfunction

    function automatic int wr_mismatch();
        int n = 0;
        for (int i = 0; i < NWR; i++) if (got_wr[i] !== exp_wr[i]) n++;
        return n;
    endfunction

    function automatic logic [127:0] exp_result();
        logic [127:0] r = '0;
        for (int i = 0; i < NRD; i++) r[i*32 +: 32] = rd_q[i];
        return r;
    endfunction

    // Entered at a falling edge with the DUT idle; leaves at a falling edge with it idle again.
    task automatic run_txn(input logic [127:0] blk, input logic [127:0] key, input int stall_idx,
                           input int stall_len, input bit rd_forever, input int ready_delay,
                           input bit hold_start);
        int cyc, xidx, sc, vcyc, post_err;
        bit handshake, fin, st;
        build_exp(blk, key);
        got_wr.delete(); rd_q.delete(); wr_cyc.delete(); rd_cyc.delete();
        res_cyc = -1; err_cnt = 0; err_cyc = -1; held = 0; bad_hold = 0; unstable = 0;
        sr_bad = 0; proto_bad = 0; rd_stalls = 0; rv_count = 0; res_first = '0;
        idle_after = 1'b0; err_idle = 1'b0;
        bus.start_valid = 1'b1; bus.blk_in = blk; bus.key_in = key;
        bus.res_ready = 1'b0; bus.avm_waitrequest = 1'b0;
        @(posedge clk);
        cyc = 0; xidx = 0; sc = 0; vcyc = 0; post_err = -1; handshake = 0; fin = 0;
        while (!fin && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (!hold_start) bus.start_valid = 1'b0;
            if (handshake) begin
                idle_after = bus.start_ready && !bus.res_valid;
                bus.res_ready = 1'b0;
                fin = 1;
            end else begin
                if (bus.avm_write && bus.avm_read) proto_bad++;
                bus.avm_waitrequest = 1'b0;
                bus.avm_readdata = $urandom;
                if (bus.avm_write || bus.avm_read) begin
                    st = (xidx == stall_idx && sc < stall_len) || (bus.avm_read && rd_forever);
                    if (xidx == stall_idx) held++;
                    if (bus.avm_write && (xidx >= NWR || bus.avm_writedata !== exp_wr[xidx])) bad_hold++;
                    bus.avm_waitrequest = st;
                    if (st) begin
                        sc++;
                        if (bus.avm_read) rd_stalls++;
                    end else begin
                        if (bus.avm_write) begin
                            got_wr.push_back(bus.avm_writedata); wr_cyc.push_back(cyc);
                        end else begin
                            rd_q.push_back(bus.avm_readdata); rd_cyc.push_back(cyc);
                        end
                        xidx++;
                    end
                end
                if (bus.err) begin
                    err_cnt++; err_cyc = cyc; post_err = 0;
                    err_idle = bus.start_ready && !bus.avm_read && !bus.avm_write;
                end
                if (post_err >= 0) begin
                    post_err++;
                    if (post_err > 3) fin = 1;
                end
                if (bus.res_valid) begin
                    rv_count++;
                    if (rv_count == 1) begin
                        res_cyc = cyc; res_first = bus.res_data;
                    end else if (bus.res_data !== res_first) unstable++;
                    if (bus.start_ready) sr_bad++;
                    if (vcyc >= ready_delay) begin
                        bus.res_ready = 1'b1; handshake = 1;
                    end
                    vcyc++;
                end
                if (bus.busy === bus.start_ready) sr_bad++;
            end
        end
        timed_out = !fin;
    endtask

    task automatic check_txn(input string tag, input int stalls, input int ready_delay);
        `CHK({tag, " finished"}, timed_out, 1'b0)
        `CHK({tag, " write count"}, got_wr.size(), int'(NWR))
        `CHK({tag, " write order/data"}, wr_mismatch(), 0)
        `CHK({tag, " held data"}, bad_hold, 0)
        `CHK({tag, " first write cycle"}, wr_cyc[0], 1)
        `CHK({tag, " res_valid cycle"}, res_cyc, 13 + stalls)
        `CHK({tag, " res_data"}, res_first, exp_result())
        `CHK({tag, " res stable"}, unstable, 0)
        `CHK({tag, " valid cycles"}, rv_count, ready_delay + 1)
        `CHK({tag, " busy/start_ready"}, sr_bad, 0)
        `CHK({tag, " rd/wr exclusive"}, proto_bad, 0)
        `CHK({tag, " idle after"}, idle_after, 1'b1)
        `CHK({tag, " no err"}, err_cnt, 0)
    endtask

    initial begin
        int nacc;
        logic [127:0] rb, rk;
        int sidx, slen, rdel;
        bus.start_valid = 1'b0; bus.blk_in = '0; bus.key_in = '0; bus.res_ready = 1'b0;
        bus.avm_readdata = '0; bus.avm_waitrequest = 1'b0;
        repeat (2) @(negedge clk);
        `CHK("reset avm_write", bus.avm_write, 1'b0)
        `CHK("reset avm_read", bus.avm_read, 1'b0)
        `CHK("reset avm_writedata", bus.avm_writedata, 32'h0)
        `CHK("reset avm_address", bus.avm_address, 1'b0)
        `CHK("reset res_valid", bus.res_valid, 1'b0)
        `CHK("reset res_data", bus.res_data, 128'h0)
        `CHK("reset err", bus.err, 1'b0)
        `CHK("reset busy", bus.busy, 1'b0)
        `CHK("reset start_ready", bus.start_ready, 1'b1)
        reset = 1'b1;
        @(negedge clk);

        run_txn(B1, K1, -1, 0, 0, 0, 0);
        check_txn("t1", 0, 0);
        `CHK("t1 word0", got_wr[0], 32'h9abcdef0)
        `CHK("t1 word2", got_wr[2], 32'hfefebabe)
        `CHK("t1 word7", got_wr[7], 32'h01234567)
        `CHK("t1 last write cycle", wr_cyc[7], 8)
        `CHK("t1 first read cycle", rd_cyc[0], 9)
        `CHK("t1 last read cycle", rd_cyc[3], 12)

        run_txn(B1, K1, 2, 3, 0, 0, 0);
        check_txn("t2", 3, 0);
        `CHK("t2 word2 held cycles", held, 4)

        run_txn(B1, K1, -1, 0, 0, 5, 0);
        check_txn("t3", 0, 5);

        run_txn(B1, K1, -1, 0, 1, 0, 0);
        `CHK("t4 finished", timed_out, 1'b0)
        `CHK("t4 write order/data", wr_mismatch(), 0)
        `CHK("t4 read stall cycles", rd_stalls, int'(TO))
        `CHK("t4 reads captured", rd_q.size(), 0)
        `CHK("t4 err pulses", err_cnt, 1)
        `CHK("t4 err cycle", err_cyc, 9 + int'(TO))
        `CHK("t4 idle at err", err_idle, 1'b1)
        `CHK("t4 res_valid count", rv_count, 0)

        bus.start_valid = 1'b1; bus.blk_in = B1; bus.key_in = K1;
        @(posedge clk);
        nacc = 0;
        for (int c = 0; c < 20 && nacc < 4; c++) begin
            @(negedge clk);
            bus.start_valid = 1'b0; bus.avm_waitrequest = 1'b0;
            if (bus.avm_write) nacc++;
        end
        @(negedge clk);
        `CHK("t5 write pending", bus.avm_write, 1'b1)
        `CHK("t5 word4 pending", bus.avm_writedata, 32'haa998877)
        reset = 1'b0;
        #1;
        `CHK("t5 async avm_write", bus.avm_write, 1'b0)
        `CHK("t5 async avm_read", bus.avm_read, 1'b0)
        `CHK("t5 async busy", bus.busy, 1'b0)
        `CHK("t5 async start_ready", bus.start_ready, 1'b1)
        @(negedge clk);
        reset = 1'b1;
        run_txn(B1, K1, -1, 0, 0, 0, 0);
        check_txn("t5", 0, 0);
        `CHK("t5 restart word0", got_wr[0], 32'h9abcdef0)

        rb = {$urandom, $urandom, $urandom, $urandom};
        rk = {$urandom, $urandom, $urandom, $urandom};
        run_txn(rb, rk, -1, 0, 0, 0, 1);
        check_txn("t6a", 0, 0);
        run_txn(rk, rb, -1, 0, 0, 1, 1);
        check_txn("t6b", 0, 1);
        bus.start_valid = 1'b0;
        @(negedge clk);
        `CHK("t6 stays idle", bus.busy, 1'b0)

        for (int n = 0; n < 8; n++) begin
            rb = {$urandom, $urandom, $urandom, $urandom};
            rk = {$urandom, $urandom, $urandom, $urandom};
            sidx = $urandom_range(0, NWR + NRD - 1);
            slen = $urandom_range(0, 6);
            rdel = $urandom_range(0, 3);
            run_txn(rb, rk, sidx, slen, 0, rdel, 0);
            check_txn($sformatf("rnd%0d", n), slen, rdel);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
